seq_mult_unit: RTL
==================

Name: seq_mult_unit

Overview:
- Multi-cycle radix-2 shift-add multiplier for the execute stage.
- Each iteration adds the multiplicand into the upper product half through a WIDTH-bit carry-lookahead adder built from the team's CLA cells.
- Uses a ready/start/done handshake toward ALU control.
- Supports signed and unsigned operands; produces a 2*WIDTH-bit product plus an overflow flag.

Parameters:
- WIDTH, 16, operand width; must be a multiple of 4 (the CLA is built from 4-bit groups).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- is_signed  in  1  treat operands as two's complement; sampled with start.
- op_a  in  WIDTH  multiplicand; sampled with start.
- op_b  in  WIDTH  multiplier; sampled with start.
- ready  out  1  unit idle and able to accept start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the product becomes valid.
- product  out  2*WIDTH  result, held until the next accepted start.
- ovf  out  1  the result does not fit in WIDTH bits; held with product.

Behaviour:
- Reset (async, any state): state=IDLE; ready=1; busy=0; done=0; product=0; ovf=0; counter and working registers=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start at edge E0, latch |op_a| and |op_b|. Magnitudes are taken only if is_signed=1 and the MSB is set; otherwise the raw value is used.
  - Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
  - Clear the accumulator; load count=WIDTH; go to CALC.
  - Also clear done; product and ovf are unchanged until FIX.
- CALC, edges E1..E_WIDTH, one iteration per edge:
  - If mult[0]=1, hi = hi + mcand via the CLA, keeping the carry-out as bit WIDTH.
  - Shift {carry, hi, mult} right by 1; count decrements.
  - When count reaches 1, go to FIX.
- FIX, edge E_WIDTH+1:
  - product = neg ? two's-complement negation of the accumulator : accumulator.
  - Compute ovf:
    - Signed: product[2W-1:W-1] is not all 0s or all 1s.
    - Unsigned: product[2W-1:W] != 0.
  - Set done=1 for exactly one cycle; go to IDLE.
- Latency: done is visible in the cycle after E_WIDTH+1, i.e. WIDTH+1 cycles after the accepting edge (17 for WIDTH=16).
- ready=1 in IDLE, including the done cycle; busy = (state != IDLE).
- start while busy: ignored, with no effect on operands or state.
- start in the done cycle: accepted; done drops the next cycle; product is held until the new FIX.
- Operand edge cases:
  - Signed -2^(W-1): magnitude 2^(W-1) fits in W unsigned bits; no special case.
  - Zero operands: the iteration count still runs; latency is fixed and never data-dependent.
- Reset mid-operation: aborts immediately to reset values; no done pulse.
- Inputs other than start are don't-care outside the accepting cycle.

Decomposition:
- Package mult_pkg:
  - State enum {IDLE, CALC, FIX}.
  - Default WIDTH.
  - Counter width constant CNT_W = clog2(WIDTH)+1.
- Sub-module cla_nb (WIDTH-bit carry-lookahead adder: a, b, cin -> sum, cout), built from the existing 4-bit group propagate/generate cells.
  - Instanced once for the accumulate.
  - Negation in FIX uses a separate inverter plus incrementer, or a second cla_nb instance with cin=1.

Test Plan:
- Unsigned: op_a=0x0003, op_b=0x0005, is_signed=0 -> done exactly 17 cycles after the accepting edge; product=0x0000000F; ovf=0.
- Unsigned max: 0xFFFF x 0xFFFF, is_signed=0 -> product=0xFFFE0001, ovf=1.
- Signed mixed: op_a=0xFFFD (-3), op_b=0x0007, is_signed=1 -> product=0xFFFFFFEB (-21), ovf=0.
- Signed corner: 0x8000 x 0x8000, is_signed=1 -> product=0x40000000, ovf=1.
- Handshake:
  - Pulse start during busy with different operands -> ignored; the original result is produced.
  - Issue start in the done cycle -> accepted; the previous product is held until the new done.
- Reset mid-operation: assert rst at cycle 8 of CALC (asynchronously, between edges) -> outputs immediately return to reset values; no done; the next start completes normally with 0x0002 x 0x0002 -> 0x00000004.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } multState_t;

  localparam int DEFAULT_WIDTH = 16;

  // Counter must hold the value WIDTH itself, hence one extra bit
  function automatic int cntWidth(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cntWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/cla_nb.sv
// rtl/cla_nb.sv - WIDTH-bit carry-lookahead adder built from 4-bit group cells
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       grpGen,
  output logic       grpProp
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] carry;

  assign gen   = a & b;
  assign prop  = a ^ b;

  assign carry[0] = cin;
  assign carry[1] = gen[0] | (prop[0] & cin);
  assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & cin);

  assign sum     = prop ^ carry;
  assign grpGen  = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign grpProp = &prop;

endmodule

module cla_nb #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP = WIDTH / 4;

  logic [NGRP:0]   grpCarry;
  logic [NGRP-1:0] grpGen;
  logic [NGRP-1:0] grpProp;

  assign grpCarry[0] = cin;

  // Group carries chain through each cell's generate/propagate pair
  for (genvar g = 0; g < NGRP; g++) begin : genGrp
    cla_group4 uGrp (
      .a       (a[4*g +: 4]),
      .b       (b[4*g +: 4]),
      .cin     (grpCarry[g]),
      .sum     (sum[4*g +: 4]),
      .grpGen  (grpGen[g]),
      .grpProp (grpProp[g])
    );
    assign grpCarry[g+1] = grpGen[g] | (grpProp[g] & grpCarry[g]);
  end

  assign cout = grpCarry[NGRP];

endmodule

// File: rtl/seq_mult_unit.sv
// rtl/seq_mult_unit.sv - radix-2 shift-add multiplier with ready/start/done handshake
module seq_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  // Package constant covers the default build; other widths derive their own
  localparam int CntW = (WIDTH == DEFAULT_WIDTH) ? CNT_W : cntWidth(WIDTH);

  multState_t state, nextState;

  logic [CntW-1:0]    cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mult;
  logic [WIDTH-1:0]   hi;
  logic               neg;
  logic               sgn;

  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH-1:0]   addSum;
  logic               addCout;
  logic [WIDTH:0]     addRes;
  logic [2*WIDTH-1:0] acc, negAcc, fixProduct;
  logic               fixOvf;

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned
  assign absA = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
  assign absB = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

  cla_nb #(.WIDTH(WIDTH)) uAdd (
    .a    (hi),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (addSum),
    .cout (addCout)
  );

  // Carry-out becomes the new top bit before the right shift
  assign addRes = mult[0] ? {addCout, addSum} : {1'b0, hi};

  assign acc        = {hi, mult};
  assign negAcc     = ~acc + (2*WIDTH)'(1);
  assign fixProduct = neg ? negAcc : acc;
  assign fixOvf     = sgn ? !((&fixProduct[2*WIDTH-1:WIDTH-1]) || !(|fixProduct[2*WIDTH-1:WIDTH-1]))
                          : (|fixProduct[2*WIDTH-1:WIDTH]);

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state selection; iteration count is fixed, never data-dependent
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = CALC;
      CALC:    if (cnt == CntW'(1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, shift-add iterations and result publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      mult    <= '0;
      hi      <= '0;
      neg     <= 1'b0;
      sgn     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= absA;
            mult  <= absB;
            hi    <= '0;
            neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            sgn   <= is_signed;
            cnt   <= CntW'(WIDTH);
          end
        end
        CALC: begin
          hi   <= addRes[WIDTH:1];
          mult <= {addRes[0], mult[WIDTH-1:1]};
          cnt  <= cnt - CntW'(1);
        end
        FIX: begin
          product <= fixProduct;
          ovf     <= fixOvf;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
